// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It covers load-use, redirect and trap
// hazards and multi-cycle I/D-cache miss waits, with saturating stall/redirect counters.
//   state | meaning
//   RUN   | normal issue, single-cycle hazard handling
//   IMISS | waiting on I-cache refill; downstream keeps draining
//   DMISS | waiting on D-cache refill; IF..MEM frozen, bubble into WB
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_redirect,
  input  logic                   mem_trap,
  input  logic                   icache_miss,
  input  logic                   icache_ready,
  input  logic                   dcache_miss,
  input  logic                   dcache_ready,
  output logic                   stall_if_id,
  output logic                   stall_id_ex,
  output logic                   stall_ex_mem,
  output logic                   stall_mem_wb,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   flush_ex_mem,
  output logic                   flush_mem_wb,
  output logic                   pc_stall,
  output logic [1:0]             pc_sel,
  output logic                   icache_abort,
  output logic [1:0]             ctrl_state,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   lu;

  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));

  assign ctrl_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // A refill completing under a load-use still returns to RUN; the held fetch simply re-hits.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN, IMISS: begin
        if (mem_trap)            state_nxt = RUN;
        else if (dcache_miss)    state_nxt = DMISS;
        else if (ex_redirect)    state_nxt = RUN;
        else if (state == IMISS) begin
          if (icache_ready) state_nxt = RUN;
        end
        else if (!lu && icache_miss) state_nxt = IMISS;
      end
      DMISS: begin
        if (dcache_ready) state_nxt = icache_miss ? IMISS : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    pc_stall     = 1'b0;
    pc_sel       = 2'd0;
    icache_abort = 1'b0;
    if (rst) begin
      pc_stall = 1'b1;
    end else if (state == DMISS) begin
      if (!dcache_ready) begin
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
        pc_stall     = 1'b1;
      end
    end else if (mem_trap) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
      pc_sel       = 2'd2;
      icache_abort = (state == IMISS);
    end else if (dcache_miss) begin
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
      pc_stall     = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      pc_sel       = 2'd1;
      icache_abort = (state == IMISS);
    end else if (lu) begin
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
      pc_stall    = 1'b1;
    end else if (state == IMISS) begin
      if (!icache_ready) begin
        flush_if_id = 1'b1;
        pc_stall    = 1'b1;
      end
    end else if (icache_miss) begin
      flush_if_id = 1'b1;
      pc_stall    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (pc_stall && (stall_cycles != {STALL_CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      if ((pc_sel != 2'd0) && (redirect_count != {FLUSH_CNT_W{1'b1}}))
        redirect_count <= redirect_count + FLUSH_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, random run against a rule-level model,
// and a saturation run on a narrow-counter instance sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       redir;
    logic       trap;
    logic       im;
    logic       ir;
    logic       dm;
    logic       dr;
  } in_t;

  typedef struct {
    in_t        x;
    logic [11:0] o;
    logic [1:0]  st;
    int          sc;
    int          rc;
  } vec_t;

  // {stall if_id,id_ex,ex_mem,mem_wb, flush if_id,id_ex,ex_mem,mem_wb, pc_stall, pc_sel[1:0], abort}
  localparam logic [11:0] O_NONE  = 12'b0000_0000_0_00_0;
  localparam logic [11:0] O_RST   = 12'b0000_0000_1_00_0;
  localparam logic [11:0] O_DMISS = 12'b1110_0001_1_00_0;
  localparam logic [11:0] O_LU    = 12'b1000_0100_1_00_0;
  localparam logic [11:0] O_IWAIT = 12'b0000_1000_1_00_0;
  localparam logic [11:0] O_REDIR = 12'b0000_1100_0_01_0;
  localparam logic [11:0] O_TRAP  = 12'b0000_1111_0_10_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect, mem_trap;
  logic       icache_miss, icache_ready, dcache_miss, dcache_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic pc_stall, icache_abort;
  logic [1:0]  pc_sel, ctrl_state;
  logic [31:0] stall_cycles;
  logic [15:0] redirect_count;

  logic s_stall_if_id, s_stall_id_ex, s_stall_ex_mem, s_stall_mem_wb;
  logic s_flush_if_id, s_flush_id_ex, s_flush_ex_mem, s_flush_mem_wb;
  logic s_pc_stall, s_icache_abort;
  logic [1:0] s_pc_sel, s_ctrl_state;
  logic [3:0] s_stall_cycles;
  logic [1:0] s_redirect_count;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_trap(mem_trap),
    .icache_miss(icache_miss), .icache_ready(icache_ready),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .pc_stall(pc_stall), .pc_sel(pc_sel), .icache_abort(icache_abort),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  pipeline_hazard_ctrl #(.STALL_CNT_W(4), .FLUSH_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_trap(mem_trap),
    .icache_miss(icache_miss), .icache_ready(icache_ready),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .stall_if_id(s_stall_if_id), .stall_id_ex(s_stall_id_ex),
    .stall_ex_mem(s_stall_ex_mem), .stall_mem_wb(s_stall_mem_wb),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .flush_ex_mem(s_flush_ex_mem), .flush_mem_wb(s_flush_mem_wb),
    .pc_stall(s_pc_stall), .pc_sel(s_pc_sel), .icache_abort(s_icache_abort),
    .ctrl_state(s_ctrl_state), .stall_cycles(s_stall_cycles), .redirect_count(s_redirect_count)
  );

  wire [11:0] dut_o = {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                       pc_stall, pc_sel, icache_abort};
  wire [11:0] sat_o = {s_stall_if_id, s_stall_id_ex, s_stall_ex_mem, s_stall_mem_wb,
                       s_flush_if_id, s_flush_id_ex, s_flush_ex_mem, s_flush_mem_wb,
                       s_pc_stall, s_pc_sel, s_icache_abort};

  int checks = 0;
  int errors = 0;

  // model state: 0 RUN, 1 IMISS, 2 DMISS
  int          m_st;
  longint      m_sc, m_rc, m_ssc, m_src;
  vec_t        tbl[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic in_t mk(input logic r, input logic ld, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                             input logic u2, input logic redir, input logic trap,
                             input logic im, input logic ir, input logic dm, input logic dr);
    in_t x;
    x.rst = r; x.ld = ld; x.rd = rd; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.redir = redir; x.trap = trap; x.im = im; x.ir = ir; x.dm = dm; x.dr = dr;
    return x;
  endfunction

  function automatic bit hazard(input in_t x);
    return x.ld && (x.rd != 0) && ((x.u1 && x.rd == x.rs1) || (x.u2 && x.rd == x.rs2));
  endfunction

  // Rule-level reference: pick the winning action, then look up its output pattern.
  function automatic void model(input int st, input in_t x, output logic [11:0] o, output int nst);
    bit lu = hazard(x);
    o = O_NONE;
    nst = st;
    if (x.rst) begin
      o = O_RST; nst = 0;
    end else if (st == 2) begin
      if (x.dr) nst = x.im ? 1 : 0;
      else      o = O_DMISS;
    end else if (x.trap) begin
      o = O_TRAP | {11'd0, st == 1}; nst = 0;
    end else if (x.dm) begin
      o = O_DMISS; nst = 2;
    end else if (x.redir) begin
      o = O_REDIR | {11'd0, st == 1}; nst = 0;
    end else if (st == 1) begin
      o = lu ? O_LU : (x.ir ? O_NONE : O_IWAIT);
      if (x.ir) nst = 0;
    end else if (lu) begin
      o = O_LU;
    end else if (x.im) begin
      o = O_IWAIT; nst = 1;
    end
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst; ex_is_load = x.ld; ex_rd = x.rd; id_rs1 = x.rs1; id_uses_rs1 = x.u1;
    id_rs2 = x.rs2; id_uses_rs2 = x.u2; ex_redirect = x.redir; mem_trap = x.trap;
    icache_miss = x.im; icache_ready = x.ir; dcache_miss = x.dm; dcache_ready = x.dr;
  endtask

  // Called just after a falling edge; checks mid-cycle, then advances one clock.
  task automatic step(input in_t x);
    logic [11:0] eo;
    int ns;
    drive(x);
    #1;
    model(m_st, x, eo, ns);
    chk("outputs", {20'd0, dut_o}, {20'd0, eo});
    chk("sat_outputs", {20'd0, sat_o}, {20'd0, eo});
    chk("ctrl_state", {30'd0, ctrl_state}, m_st);
    chk("stall_cycles", stall_cycles, m_sc[31:0]);
    chk("redirect_count", {16'd0, redirect_count}, m_rc[31:0]);
    chk("sat_stall_cycles", {28'd0, s_stall_cycles}, m_ssc[31:0]);
    chk("sat_redirect_count", {30'd0, s_redirect_count}, m_src[31:0]);
    if (x.rst) begin
      m_sc = 0; m_rc = 0; m_ssc = 0; m_src = 0;
    end else begin
      if (eo[3]) begin
        m_sc  = (m_sc == 64'hFFFF_FFFF) ? m_sc : m_sc + 1;
        m_ssc = (m_ssc == 15) ? m_ssc : m_ssc + 1;
      end
      if (eo[2:1] != 2'd0) begin
        m_rc  = (m_rc == 65535) ? m_rc : m_rc + 1;
        m_src = (m_src == 3) ? m_src : m_src + 1;
      end
    end
    m_st = ns;
    @(negedge clk);
  endtask

  initial begin
    in_t x;
    //                 rst ld rd rs1 u1 rs2 u2 rdr trp im ir dm dr
    tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RST,   2'd0,  0, 0};
    tbl[1]  = '{mk(0, 1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0), O_LU,    2'd0,  0, 0};
    tbl[2]  = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), O_NONE,  2'd0,  1, 0};
    tbl[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DMISS, 2'd0,  1, 0};
    tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), O_DMISS, 2'd2,  2, 0};
    tbl[5]  = '{mk(0, 1, 3, 3, 1, 0, 0, 0, 1, 0, 0, 1, 0), O_DMISS, 2'd2,  3, 0};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DMISS, 2'd2,  4, 0};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_NONE,  2'd2,  5, 0};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_IWAIT, 2'd0,  5, 0};
    tbl[9]  = '{mk(0, 1, 7, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0), O_LU,    2'd1,  6, 0};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_IWAIT, 2'd1,  7, 0};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), O_REDIR | 12'd1, 2'd1, 8, 0};
    tbl[12] = '{mk(0, 1, 4, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0), O_TRAP,  2'd0,  8, 1};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_IWAIT, 2'd0,  8, 2};
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_NONE,  2'd1,  9, 2};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_IWAIT, 2'd0,  9, 2};
    tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), O_TRAP | 12'd1, 2'd1, 10, 2};
    tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DMISS, 2'd0, 10, 3};
    tbl[18] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), O_NONE,  2'd2, 11, 3};
    tbl[19] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_IWAIT, 2'd1, 11, 3};
    tbl[20] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RST,   2'd1, 12, 3};
    tbl[21] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RST,   2'd0,  0, 0};
    tbl[22] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE,  2'd0,  0, 0};

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    m_st = 0; m_sc = 0; m_rc = 0; m_ssc = 0; m_src = 0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].x);
      #1;
      chk($sformatf("tbl%0d_outputs", i), {20'd0, dut_o}, {20'd0, tbl[i].o});
      chk($sformatf("tbl%0d_state", i), {30'd0, ctrl_state}, {30'd0, tbl[i].st});
      chk($sformatf("tbl%0d_stall_cycles", i), stall_cycles, tbl[i].sc);
      chk($sformatf("tbl%0d_redirect_count", i), {16'd0, redirect_count}, tbl[i].rc);
      #1;
      step(tbl[i].x);
    end

    for (int n = 0; n < 3000; n++) begin
      x.rst   = ($urandom_range(0, 99) == 0);
      x.ld    = $urandom_range(0, 1);
      x.rd    = 5'($urandom_range(0, 7));
      x.rs1   = 5'($urandom_range(0, 7));
      x.u1    = $urandom_range(0, 1);
      x.rs2   = 5'($urandom_range(0, 7));
      x.u2    = $urandom_range(0, 1);
      x.redir = ($urandom_range(0, 7) == 0);
      x.trap  = ($urandom_range(0, 15) == 0);
      x.im    = ($urandom_range(0, 4) == 0);
      x.ir    = ($urandom_range(0, 2) == 0);
      x.dm    = ($urandom_range(0, 7) == 0);
      x.dr    = ($urandom_range(0, 2) == 0);
      if (m_st == 1 && hazard(x)) x.ir = 1'b0;
      step(x);
    end

    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 20; n++)
      step(mk(0, 1, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("sat_stall_held_at_15", {28'd0, s_stall_cycles}, 32'd15);
    chk("wide_stall_after_20", stall_cycles, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
